// File: rtl/oa21_pipe_if.sv
// Handshake/data bundle for oa21_pipe_array. The slave side is the pipeline and the master side is its driver.
// When OA21_PARITY_EN is defined, the bundle also carries the parity output qp.
interface oa21_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
);
  logic             vld_in;
  logic             rdy_in;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic [WIDTH-1:0] q;
  logic             vld_out;
  logic             rdy_out;
  logic [CNTW-1:0]  cnt;
`ifdef OA21_PARITY_EN
  logic             qp;

  modport master (
    output vld_in, in1, in2, in3, rdy_out,
    input  rdy_in, q, vld_out, cnt, qp
  );
  modport slave (
    input  vld_in, in1, in2, in3, rdy_out,
    output rdy_in, q, vld_out, cnt, qp
  );
`else
  modport master (
    output vld_in, in1, in2, in3, rdy_out,
    input  rdy_in, q, vld_out, cnt
  );
  modport slave (
    input  vld_in, in1, in2, in3, rdy_out,
    output rdy_in, q, vld_out, cnt
  );
`endif
endinterface

// File: rtl/oa21_pipe_array.sv
// Pipelined bitwise OA21 array: q = (in1 | in2) & in3 through STAGES registers with a global-stall handshake.
// Optional macro OA21_PARITY_EN adds a per-stage even-parity bit and the qp output.
module oa21_pipe_array #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNTW   = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  oa21_pipe_if.slave    bus
);

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_dat [STAGES];
  logic [CNTW-1:0]  r_cnt;
`ifdef OA21_PARITY_EN
  logic             r_par [STAGES];
`endif

  logic             w_adv;
  logic [WIDTH-1:0] w_oa21;
  logic             w_out_acc;

  // The whole pipe moves as one unit; empty inner stages never squeeze out a stall.
  assign w_adv     = !r_vld[STAGES-1] | bus.rdy_out;
  assign w_oa21    = (bus.in1 | bus.in2) & bus.in3;
  assign w_out_acc = r_vld[STAGES-1] & bus.rdy_out;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k] <= 1'b0;
        r_dat[k] <= '0;
`ifdef OA21_PARITY_EN
        r_par[k] <= 1'b0;
`endif
      end
    end else if (w_adv) begin
      r_vld[0] <= bus.vld_in;
      r_dat[0] <= bus.vld_in ? w_oa21 : '0;
`ifdef OA21_PARITY_EN
      r_par[0] <= bus.vld_in ? ^w_oa21 : 1'b0;
`endif
      for (int k = 1; k < STAGES; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_dat[k] <= r_dat[k-1];
`ifdef OA21_PARITY_EN
        r_par[k] <= r_par[k-1];
`endif
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_out_acc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.rdy_in  = w_adv;
  assign bus.q       = r_dat[STAGES-1];
  assign bus.vld_out = r_vld[STAGES-1];
  assign bus.cnt     = r_cnt;
`ifdef OA21_PARITY_EN
  assign bus.qp      = r_par[STAGES-1];
`endif

endmodule
